ps2_key_decoder: RTL and testbench

- Receives PS/2 keyboard frames and turns them into held-key levels: up, down, left, right, fire.
- These levels drive the player tank movement/fire logic.
- Covers make/break codes and E0-extended arrow keys.
- Sits between the board PS/2 pins and the player movement logic, in the system clock domain.

---
 rtl/ps2_key_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that turns make/break scan codes into held-key levels
// for the player tank controls (WASD / arrows / space).
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       fire,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  localparam int K_W     = 0;
  localparam int K_S     = 1;
  localparam int K_A     = 2;
  localparam int K_D     = 3;
  localparam int K_SPACE = 4;
  localparam int K_UP    = 5;
  localparam int K_DOWN  = 6;
  localparam int K_LEFT  = 7;
  localparam int K_RIGHT = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_next;
  logic [1:0]       clk_sync, data_sync;
  logic             filt_level;
  logic [FCW-1:0]   filt_cnt;
  logic             fall_strobe;
  logic             sample;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_bit, parity_next;
  logic [TCW-1:0]   timeout_cnt;
  logic             frame_good, frame_bad;
  logic             ext, ext_next, brk, brk_next;
  logic [8:0]       held, held_next;
  logic             key_hit;
  logic [3:0]       key_idx;

  // Synchronisers idle high, matching the PS/2 bus idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign sample = data_sync[1];

  // Level only flips after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_level  <= 1'b1;
      filt_cnt    <= '0;
      fall_strobe <= 1'b0;
    end else begin
      fall_strobe <= 1'b0;
      if (clk_sync[1] == filt_level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_level  <= clk_sync[1];
        filt_cnt    <= '0;
        fall_strobe <= filt_level;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
    end
  end

  // Timeout has priority only when no edge arrives in the same cycle
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    frame_good   = 1'b0;
    frame_bad    = 1'b0;
    if (state != IDLE && !fall_strobe && timeout_cnt == TO_LAST) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      frame_bad    = 1'b1;
    end else if (fall_strobe) begin
      case (state)
        IDLE: begin
          if (!sample) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            frame_bad = 1'b1;
          end
        end
        DATA: begin
          shift_next   = {sample, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = sample;
          state_next  = STOP;
        end
        STOP: begin
          if (sample && (^{shift_reg, parity_bit})) frame_good = 1'b1;
          else                                      frame_bad  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if (state == IDLE || fall_strobe) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TCW'(1);
    end
  end

  // Prefix bytes only arm flags; any other good byte consumes and clears them
  always_comb begin
    ext_next  = ext;
    brk_next  = brk;
    held_next = held;
    key_hit   = 1'b0;
    key_idx   = 4'd0;
    if (frame_good) begin
      if (shift_reg == 8'hE0) begin
        ext_next = 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_next = 1'b1;
      end else begin
        if (!ext) begin
          case (shift_reg)
            8'h1D:   begin key_hit = 1'b1; key_idx = 4'(K_W);     end
            8'h1B:   begin key_hit = 1'b1; key_idx = 4'(K_S);     end
            8'h1C:   begin key_hit = 1'b1; key_idx = 4'(K_A);     end
            8'h23:   begin key_hit = 1'b1; key_idx = 4'(K_D);     end
            8'h29:   begin key_hit = 1'b1; key_idx = 4'(K_SPACE); end
            default: key_hit = 1'b0;
          endcase
        end else begin
          case (shift_reg)
            8'h75:   begin key_hit = 1'b1; key_idx = 4'(K_UP);    end
            8'h72:   begin key_hit = 1'b1; key_idx = 4'(K_DOWN);  end
            8'h6B:   begin key_hit = 1'b1; key_idx = 4'(K_LEFT);  end
            8'h74:   begin key_hit = 1'b1; key_idx = 4'(K_RIGHT); end
            default: key_hit = 1'b0;
          endcase
        end
        if (key_hit) held_next[key_idx] = ~brk;
        ext_next = 1'b0;
        brk_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      held       <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      fire       <= 1'b0;
    end else begin
      ext        <= ext_next;
      brk        <= brk_next;
      held       <= held_next;
      code_valid <= frame_good;
      frame_err  <= frame_bad;
      if (frame_good) code <= shift_reg;
      up         <= held_next[K_W] | held_next[K_UP];
      down       <= held_next[K_S] | held_next[K_DOWN];
      left       <= held_next[K_A] | held_next[K_LEFT];
      right      <= held_next[K_D] | held_next[K_RIGHT];
      fire       <= held_next[K_SPACE];
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives slow PS/2 frames and checks
// key levels, code pulses and error pulses against hand-computed values.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, fire;
  logic       code_valid, frame_err;
  logic [7:0] code;

  int         checks = 0;
  int         passed = 0;
  int         cv_count = 0;
  int         fe_count = 0;
  logic [7:0] last_code = 8'h00;
  int         cv0, fe0;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .fire(fire),
    .code_valid(code_valid), .code(code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (code_valid) begin
      cv_count++;
      last_code = code;
    end
    if (frame_err) fe_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic ps2Bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB-first, parity, stop)
  task automatic applyStimulus(input logic [7:0] b, input logic flip_par, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2Bit(frame[i]);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [4:0] keys();
    return {up, down, left, right, fire};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_keys", 32'(keys()), 32'h0);
    checkOutput("reset_code", 32'(code), 32'h0);
    checkOutput("reset_code_valid", 32'(code_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] make W");
    cv0 = cv_count;
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("w_cv_pulses", 32'(cv_count - cv0), 32'd1);
    checkOutput("w_code", 32'(last_code), 32'h1D);
    checkOutput("w_keys", 32'(keys()), 32'b10000);
    repeat (100) @(negedge clk);
    checkOutput("w_up_stays", 32'(up), 32'd1);

    $display("[TB] break W");
    cv0 = cv_count;
    applyStimulus(8'hF0, 1'b0, 11);
    checkOutput("f0_cv_pulses", 32'(cv_count - cv0), 32'd1);
    checkOutput("f0_up_still", 32'(up), 32'd1);
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("brk_cv_pulses", 32'(cv_count - cv0), 32'd2);
    checkOutput("brk_up", 32'(up), 32'd0);
    checkOutput("brk_code", 32'(last_code), 32'h1D);

    $display("[TB] extended left and space");
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h6B, 1'b0, 11);
    applyStimulus(8'h29, 1'b0, 11);
    checkOutput("left_fire_keys", 32'(keys()), 32'b00101);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'hF0, 1'b0, 11);
    applyStimulus(8'h6B, 1'b0, 11);
    checkOutput("left_released_keys", 32'(keys()), 32'b00001);

    $display("[TB] parity error");
    cv0 = cv_count;
    fe0 = fe_count;
    applyStimulus(8'h1B, 1'b1, 11);
    checkOutput("par_fe_pulses", 32'(fe_count - fe0), 32'd1);
    checkOutput("par_cv_pulses", 32'(cv_count - cv0), 32'd0);
    checkOutput("par_keys", 32'(keys()), 32'b00001);
    applyStimulus(8'h1B, 1'b0, 11);
    checkOutput("s_keys", 32'(keys()), 32'b01001);

    $display("[TB] timeout");
    cv0 = cv_count;
    fe0 = fe_count;
    applyStimulus(8'h23, 1'b0, 5);
    repeat (TIMEOUT + 50) @(negedge clk);
    checkOutput("to_fe_pulses", 32'(fe_count - fe0), 32'd1);
    checkOutput("to_cv_pulses", 32'(cv_count - cv0), 32'd0);
    applyStimulus(8'h23, 1'b0, 11);
    checkOutput("d_keys", 32'(keys()), 32'b01011);
    checkOutput("d_code", 32'(last_code), 32'h23);

    $display("[TB] async reset mid-frame");
    applyStimulus(8'h29, 1'b0, 4);
    checkOutput("pre_rst_fire", 32'(fire), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_keys", 32'(keys()), 32'h0);
    checkOutput("rst_code", 32'(code), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    cv0 = cv_count;
    fe0 = fe_count;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("glitch_fe", 32'(fe_count - fe0), 32'd0);
    checkOutput("glitch_cv", 32'(cv_count - cv0), 32'd0);
    applyStimulus(8'h1D, 1'b0, 11);
    checkOutput("post_rst_cv", 32'(cv_count - cv0), 32'd1);
    checkOutput("post_rst_code", 32'(last_code), 32'h1D);
    checkOutput("post_rst_keys", 32'(keys()), 32'b10000);
    checkOutput("post_rst_fe", 32'(fe_count - fe0), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
